// File: rtl/sc_edge_sched.sv
// sc_edge_sched: stochastic-computing edge-detector scheduler.
// Accepts a 2x2 pixel window and turns it into four correlated stochastic
// streams plus an add/sub select stream for an external datapath. It then
// counts the ones on the datapath output over one window and presents the
// count as mag.
// Optional feature macro SC_EDGE_SCHED_THRESH_EN adds a thresh input and a
// registered compare output. "edge" is a reserved word, so that output is
// named edge_flag.
module sc_edge_sched #(
  parameter int unsigned STREAM_LEN = 256,
  parameter int unsigned DP_LAT     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] p00,
  input  logic [7:0] p01,
  input  logic [7:0] p10,
  input  logic [7:0] p11,
  output logic       r00,
  output logic       r01,
  output logic       r10,
  output logic       r11,
  output logic       sel,
  output logic       dp_rst,
  input  logic       s,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] mag
`ifdef SC_EDGE_SCHED_THRESH_EN
  ,
  input  logic [8:0] thresh,
  output logic       edge_flag
`endif
);

  localparam logic [7:0] SeedA     = 8'h01;
  localparam logic [7:0] SeedB     = 8'hB4;
  localparam logic [8:0] RunLast   = 9'(STREAM_LEN - 1);
  localparam logic [8:0] DpLat9    = 9'(DP_LAT);
  localparam logic [2:0] DrainLast = (DP_LAT == 0) ? 3'd0 : 3'(DP_LAT - 1);
  localparam logic [8:0] CountMax  = 9'd256;

  typedef enum logic [2:0] {StIdle, StClear, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      lfsr_a_q, lfsr_a_d;
  logic [7:0]      lfsr_b_q, lfsr_b_d;
  logic [8:0]      count_q, count_d;
  logic [8:0]      run_cnt_q, run_cnt_d;
  logic [2:0]      drain_cnt_q, drain_cnt_d;
  logic [3:0][7:0] pix_q, pix_d;
  logic [8:0]      mag_q, mag_d;
  logic            out_valid_q, out_valid_d;
  logic            edge_q, edge_d;
  logic [8:0]      count_inc;
  logic            run;

  // Fibonacci LFSR, shift left, taps 8,6,5,4 (maximal length 255).
  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Saturating increment; a window never exceeds 256 samples, but never wrap.
  assign count_inc = (count_q == CountMax) ? count_q : count_q + 9'd1;

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      lfsr_a_q    <= SeedA;
      lfsr_b_q    <= SeedB;
      count_q     <= '0;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      pix_q       <= '0;
      mag_q       <= '0;
      out_valid_q <= 1'b0;
      edge_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_a_q    <= lfsr_a_d;
      lfsr_b_q    <= lfsr_b_d;
      count_q     <= count_d;
      run_cnt_q   <= run_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pix_q       <= pix_d;
      mag_q       <= mag_d;
      out_valid_q <= out_valid_d;
      edge_q      <= edge_d;
    end
  end

  // Next-state logic: window sequencing, LFSR stepping and ones counting.
  always_comb begin
    state_d     = state_q;
    lfsr_a_d    = lfsr_a_q;
    lfsr_b_d    = lfsr_b_q;
    count_d     = count_q;
    run_cnt_d   = run_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pix_d       = pix_q;
    mag_d       = mag_q;
    out_valid_d = out_valid_q;
    edge_d      = edge_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pix_d   = {p11, p10, p01, p00};
          state_d = StClear;
        end
      end
      StClear: begin
        lfsr_a_d    = SeedA;
        lfsr_b_d    = SeedB;
        count_d     = '0;
        run_cnt_d   = '0;
        drain_cnt_d = '0;
        state_d     = StRun;
      end
      StRun: begin
        lfsr_a_d  = lfsr_next(lfsr_a_q);
        lfsr_b_d  = lfsr_next(lfsr_b_q);
        run_cnt_d = run_cnt_q + 9'd1;
        // The first DP_LAT output samples still reflect the cleared datapath.
        if (run_cnt_q >= DpLat9 && s) count_d = count_inc;
        if (run_cnt_q == RunLast) state_d = (DP_LAT == 0) ? StDone : StDrain;
      end
      StDrain: begin
        drain_cnt_d = drain_cnt_q + 3'd1;
        if (s) count_d = count_inc;
        if (drain_cnt_q == DrainLast) state_d = StDone;
      end
      StDone: begin
        // First DONE cycle registers the result; it is offered from the next.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          mag_d       = count_q;
`ifdef SC_EDGE_SCHED_THRESH_EN
          edge_d      = (count_q >= thresh);
`endif
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; reset overrides the handshake and holds the datapath cleared.
  always_comb begin
    run       = (state_q == StRun);
    in_ready  = (state_q == StIdle) && !rst;
    dp_rst    = (state_q == StClear) || rst;
    r00       = run && (pix_q[0] > lfsr_a_q);
    r01       = run && (pix_q[1] > lfsr_a_q);
    r10       = run && (pix_q[2] > lfsr_a_q);
    r11       = run && (pix_q[3] > lfsr_a_q);
    sel       = run && lfsr_b_q[7];
    out_valid = out_valid_q;
    mag       = mag_q;
  end

`ifdef SC_EDGE_SCHED_THRESH_EN
  assign edge_flag = edge_q;
`else
  logic unused_edge;
  assign unused_edge = edge_q;
`endif

endmodule
